// File: rtl/imm_rotate_encoder_if.sv
// imm_rotate_encoder_if: request/result bundle for the immediate encoder.
interface imm_rotate_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic        negated;
    logic [11:0] shift_operand;
    modport master (output start, value, input busy, done, valid, negated, shift_operand);
    modport slave (input start, value, output busy, done, valid, negated, shift_operand);
endinterface

// File: rtl/imm_rotate_encoder.sv
// imm_rotate_encoder: iterative search for the smallest even rotation encoding a 32-bit constant.
// Define IMM_ENC_NEG_EN to also accept ~value (MVN form), reported on negated.
module imm_rotate_encoder (
    input logic clk,
    input logic rst,
    imm_rotate_encoder_if.slave bus
);
    typedef enum logic {IDLE, SEARCH} state_t;
    state_t      state_q, state_d;
    logic [31:0] val_q, val_d, t;
    logic [3:0]  rot_q, rot_d;
    logic        done_q, done_d, valid_q, valid_d, neg_q, neg_d;
    logic [11:0] so_q, so_d;
    logic [63:0] t_dbl;
    logic        hit, hit_neg;
    logic [7:0]  imm;
    assign t_dbl = {val_q, val_q} << {rot_q, 1'b0};
    assign t = t_dbl[63:32];
`ifdef IMM_ENC_NEG_EN
    logic [63:0] u_dbl;
    logic [31:0] u;
    assign u_dbl = {~val_q, ~val_q} << {rot_q, 1'b0};
    assign u = u_dbl[63:32];
    // t wins over u at the same rotation so MOV is preferred to MVN
    assign hit = t[31:8] == 24'd0 || u[31:8] == 24'd0;
    assign hit_neg = t[31:8] != 24'd0;
    assign imm = hit_neg ? u[7:0] : t[7:0];
`else
    assign hit = t[31:8] == 24'd0;
    assign hit_neg = 1'b0;
    assign imm = t[7:0];
`endif
    always_comb begin
        state_d = state_q;
        val_d = val_q;
        rot_d = rot_q;
        done_d = 1'b0;
        valid_d = valid_q;
        neg_d = neg_q;
        so_d = so_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = SEARCH;
                val_d = bus.value;
                rot_d = 4'd0;
            end
        end else if (hit) begin
            state_d = IDLE;
            done_d = 1'b1;
            valid_d = 1'b1;
            neg_d = hit_neg;
            so_d = {rot_q, imm};
        end else if (rot_q == 4'd15) begin
            state_d = IDLE;
            done_d = 1'b1;
            valid_d = 1'b0;
            neg_d = 1'b0;
            so_d = 12'h000;
        end else begin
            rot_d = rot_q + 4'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            val_q <= 32'd0;
            rot_q <= 4'd0;
            done_q <= 1'b0;
            valid_q <= 1'b0;
            neg_q <= 1'b0;
            so_q <= 12'h000;
        end else begin
            state_q <= state_d;
            val_q <= val_d;
            rot_q <= rot_d;
            done_q <= done_d;
            valid_q <= valid_d;
            neg_q <= neg_d;
            so_q <= so_d;
        end
    end
    assign bus.busy = state_q == SEARCH;
    assign bus.done = done_q;
    assign bus.valid = valid_q;
    assign bus.negated = neg_q;
    assign bus.shift_operand = so_q;
endmodule
